// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle logic/arithmetic ops plus iterative
// (one bit per cycle) 32x32 multiply and, optionally, divide.
// Optional feature macro: ALU_DIV_EN -- when defined, hardware divide
// (DIVU 1101 / DIV 1111) is built; otherwise those codes report ill.
// Signed multiply/divide run on magnitudes; the sign is applied in FIXUP.
module alu_exec_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] lo,
   output logic [31:0] hi,
   output logic        zero,
   output logic        ovf,
   output logic        dz,
   output logic        ill,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_lo;
   logic [31:0] r_hi;
   logic        r_ovf;
   logic        r_dz;
   logic        r_ill;
   logic [63:0] r_acc;       // mul: partial product; div: {remainder, quotient}
   logic [31:0] r_mb;        // mul: multiplicand magnitude; div: divisor magnitude
   logic [4:0]  r_cnt;
   logic        r_neg_res;   // product/quotient must be negated in FIXUP
`ifdef ALU_DIV_EN
   logic        r_op_div;
   logic        r_neg_a;     // remainder takes the sign of the dividend
   logic        r_b_zero;
`endif

   // single-cycle datapath
   logic [31:0] w_sum;
   logic [31:0] w_diff;
   logic        w_slt;
   logic        w_sltu;
   logic [31:0] w_sc_lo;
   logic        w_sc_ovf;
   logic        w_sc_ill;

   // multi-cycle decode and datapath
   logic        w_is_mul;
   logic        w_is_div;
   logic        w_multi;
   logic        w_signed;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic [63:0] w_prod_fix;
   logic [63:0] w_iter_next;
   logic [31:0] w_fix_lo;
   logic [31:0] w_fix_hi;
   logic        w_fix_dz;

   assign w_sum  = a + b;
   assign w_diff = a - b;
   assign w_slt  = $signed(a) < $signed(b);
   assign w_sltu = a < b;

   assign w_is_mul = (ctrl == 4'b1100) || (ctrl == 4'b1110);
`ifdef ALU_DIV_EN
   assign w_is_div = (ctrl == 4'b1101) || (ctrl == 4'b1111);
`else
   assign w_is_div = 1'b0;
`endif
   assign w_multi  = w_is_mul || w_is_div;
   assign w_signed = ctrl[1];   // 1110/1111 are the signed mul/div codes

   assign w_abs_a = (w_signed && a[31]) ? (32'd0 - a) : a;
   assign w_abs_b = (w_signed && b[31]) ? (32'd0 - b) : b;

   // shift-add multiply step: add multiplicand when the low multiplier bit is set
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mb} : 33'd0);
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};
   assign w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;

`ifdef ALU_DIV_EN
   // restoring divide step: shift in next dividend bit, subtract divisor if it fits
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic [63:0] w_div_next;
   assign w_div_shift = r_acc[63:31];
   assign w_div_diff  = w_div_shift - {1'b0, r_mb};
   assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                       : {w_div_diff[31:0],  r_acc[30:0], 1'b1};
`endif

   // single-cycle result and flag decode
   always_comb begin
      w_sc_lo  = 32'd0;
      w_sc_ovf = 1'b0;
      w_sc_ill = 1'b0;
      case (ctrl)
         4'b0000: w_sc_lo = a & b;
         4'b0001: w_sc_lo = a | b;
         4'b0010: w_sc_lo = w_sum;
         4'b0011: w_sc_lo = w_diff;
         4'b0100: w_sc_lo = {31'd0, w_slt};
         4'b0101: w_sc_lo = {31'd0, w_sltu};
         4'b0111: w_sc_lo = ~(a | b);
         4'b1010: begin
            w_sc_lo  = w_sum;
            w_sc_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
         end
         4'b1011: begin
            w_sc_lo  = w_diff;
            w_sc_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);
         end
         default: w_sc_ill = 1'b1;  // multi-cycle codes never take this path
      endcase
   end

   // select iteration step and final sign/divide-by-zero fixup
   always_comb begin
      w_iter_next = w_mul_next;
      w_fix_lo    = w_prod_fix[31:0];
      w_fix_hi    = w_prod_fix[63:32];
      w_fix_dz    = 1'b0;
`ifdef ALU_DIV_EN
      if (r_op_div) begin
         w_iter_next = w_div_next;
         w_fix_lo    = r_b_zero  ? 32'hFFFF_FFFF
                     : (r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
         w_fix_hi    = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
         w_fix_dz    = r_b_zero;
      end
`endif
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // FSM next-state and status outputs
   always_comb begin
      w_state_next = r_state;
      busy         = (r_state != IDLE);
      done         = (r_state == DONE);
      case (r_state)
         IDLE:    if (start) w_state_next = w_multi ? ITER : DONE;
         ITER:    if (r_cnt == 5'd31) w_state_next = FIXUP;
         FIXUP:   w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // datapath: capture operands on start, iterate, then write results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lo      <= 32'd0;
         r_hi      <= 32'd0;
         r_ovf     <= 1'b0;
         r_dz      <= 1'b0;
         r_ill     <= 1'b0;
         r_acc     <= 64'd0;
         r_mb      <= 32'd0;
         r_cnt     <= 5'd0;
         r_neg_res <= 1'b0;
`ifdef ALU_DIV_EN
         r_op_div  <= 1'b0;
         r_neg_a   <= 1'b0;
         r_b_zero  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ovf <= 1'b0;
                  r_dz  <= 1'b0;
                  r_ill <= 1'b0;
                  if (w_multi) begin
                     r_cnt     <= 5'd0;
                     r_neg_res <= w_signed && (a[31] ^ b[31]);
                     if (w_is_div) begin
                        r_acc <= {32'd0, w_abs_a};
                        r_mb  <= w_abs_b;
                     end else begin
                        r_acc <= {32'd0, w_abs_b};
                        r_mb  <= w_abs_a;
                     end
`ifdef ALU_DIV_EN
                     r_op_div <= w_is_div;
                     r_neg_a  <= w_signed && a[31];
                     r_b_zero <= (b == 32'd0);
`endif
                  end else begin
                     r_lo  <= w_sc_lo;
                     r_hi  <= 32'd0;
                     r_ovf <= w_sc_ovf;
                     r_ill <= w_sc_ill;
                  end
               end
            end
            ITER: begin
               r_acc <= w_iter_next;
               r_cnt <= r_cnt + 5'd1;
            end
            FIXUP: begin
               r_lo <= w_fix_lo;
               r_hi <= w_fix_hi;
               r_dz <= w_fix_dz;
            end
            default: ;
         endcase
      end
   end

   assign lo   = r_lo;
   assign hi   = r_hi;
   assign zero = (r_lo == 32'd0);
   assign ovf  = r_ovf;
   assign dz   = r_dz;
   assign ill  = r_ill;

endmodule
